// File: rtl/stream_demux.sv
// 1-to-N packet demultiplexer for valid/ready streams with a one-entry register per output.
// Optional STREAM_DEMUX_DROP_EN: drop out-of-range packets and count them on drop_cnt.
module stream_demux #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned N_OUT  = 2,
  localparam int unsigned SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_last,
  output logic                    busy
`ifdef STREAM_DEMUX_DROP_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  typedef enum logic {IDLE, LOCK} state_e;

  state_e                  state_q, state_d;
  logic [SEL_W-1:0]        cur_sel_q, cur_sel_d;
  logic [SEL_W-1:0]        tgt;
  logic                    oor;
  logic                    drop_now;
  logic                    tgt_free;
  logic                    accept;
  logic                    load;
  logic [N_OUT-1:0]        free;
  logic [N_OUT-1:0]        out_valid_q;
  logic [N_OUT-1:0]        out_last_q;
  logic [N_OUT*DATA_W-1:0] out_data_q;

`ifdef STREAM_DEMUX_DROP_EN
  logic        drop_q, drop_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

  assign free   = ~out_valid_q | out_ready;
  assign accept = in_valid & in_ready;
  assign load   = accept & ~drop_now;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
`ifdef STREAM_DEMUX_DROP_EN
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
`ifdef STREAM_DEMUX_DROP_EN
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  // Next-state: the first beat opens a packet unless it is also the last beat
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cur_sel_d = tgt;
          if (!in_last) state_d = LOCK;
        end
      end
      LOCK: begin
        if (accept && in_last) state_d = IDLE;
      end
    endcase
  end

`ifdef STREAM_DEMUX_DROP_EN
  // Drop flag and saturating drop counter, both updated on a first beat only
  always_comb begin
    drop_d     = drop_q;
    drop_cnt_d = drop_cnt_q;
    if (state_q == IDLE && accept) begin
      drop_d = oor;
      if (oor && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end
`endif

  // Outputs of the FSM: routing target, input ready, busy
  always_comb begin
    oor      = {1'b0, in_sel} >= (SEL_W+1)'(N_OUT);
    tgt      = (state_q == LOCK) ? cur_sel_q : in_sel;
    drop_now = 1'b0;
`ifdef STREAM_DEMUX_DROP_EN
    drop_now = (state_q == IDLE) ? oor : drop_q;
`else
    if (state_q == IDLE && oor) tgt = SEL_W'(N_OUT - 1);
`endif
    tgt_free = 1'b0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      if (tgt == SEL_W'(i)) tgt_free = free[i];
    end
    in_ready = drop_now | tgt_free;
    busy     = (state_q == LOCK);
  end

  // Per-output register stage; load wins over drain so valid stays up on a same-cycle swap
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= '0;
      out_last_q  <= '0;
      out_data_q  <= '0;
    end else begin
      for (int i = 0; i < int'(N_OUT); i++) begin
        if (load && tgt == SEL_W'(i)) begin
          out_valid_q[i]                <= 1'b1;
          out_last_q[i]                 <= in_last;
          out_data_q[i*DATA_W +: DATA_W] <= in_data;
        end else if (out_ready[i]) begin
          out_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
`ifdef STREAM_DEMUX_DROP_EN
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: a 2-output instance for routing/backpressure/reset
// and a 3-output instance for the out-of-range select case (STREAM_DEMUX_DROP_EN aware).
module tb_stream_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 2-output instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data  = '0;
  logic        in_last  = 1'b0;
  logic [0:0]  in_sel   = '0;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready = 2'b11;
  logic [15:0] out_data;
  logic [1:0]  out_last;
  logic        busy;

  // 3-output instance
  logic        v3 = 1'b0;
  logic        r3;
  logic [7:0]  d3 = '0;
  logic        l3 = 1'b0;
  logic [1:0]  s3 = '0;
  logic [2:0]  ov3;
  logic [2:0]  or3 = 3'b111;
  logic [23:0] od3;
  logic [2:0]  ol3;
  logic        busy3;
`ifdef STREAM_DEMUX_DROP_EN
  logic [15:0] drop_cnt2;
  logic [15:0] drop_cnt3;
`endif

  stream_demux #(.DATA_W(8), .N_OUT(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
`ifdef STREAM_DEMUX_DROP_EN
    , .drop_cnt(drop_cnt2)
`endif
  );

  stream_demux #(.DATA_W(8), .N_OUT(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(v3), .in_ready(r3), .in_data(d3),
    .in_last(l3), .in_sel(s3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .out_last(ol3), .busy(busy3)
`ifdef STREAM_DEMUX_DROP_EN
    , .drop_cnt(drop_cnt3)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%0h expected=none", name, act);
  endtask

  // Monitor: pop and compare every beat handed over at the next rising edge
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid[0] && out_ready[0]) begin
        if (q0.size() == 0) unexpected("out0_beat", {23'd0, out_last[0], out_data[7:0]});
        else check("out0_beat", {23'd0, out_last[0], out_data[7:0]}, {23'd0, q0.pop_front()});
      end
      if (out_valid[1] && out_ready[1]) begin
        if (q1.size() == 0) unexpected("out1_beat", {23'd0, out_last[1], out_data[15:8]});
        else check("out1_beat", {23'd0, out_last[1], out_data[15:8]}, {23'd0, q1.pop_front()});
      end
      for (int i = 0; i < 3; i++) begin
        if (ov3[i] && or3[i]) begin
          if (i == 2 && q3.size() != 0)
            check("n3_out2_beat", {23'd0, ol3[2], od3[23:16]}, {23'd0, q3.pop_front()});
          else
            unexpected("n3_out_beat", {22'd0, ol3[i], 1'b0, od3[i*8 +: 8]});
        end
      end
    end
  end

  // Present one beat, wait for acceptance, record the expected output (dst<0: none)
  task automatic send2(input logic [7:0] d, input logic l, input logic s, input int dst);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_sel   = s;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (dst == 0) q0.push_back({l, d});
      else if (dst == 1) q1.push_back({l, d});
      @(posedge clk);
      #1;
    end else begin
      unexpected("send_timeout", {24'd0, d});
    end
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with in_valid held high
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_out_valid", {30'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 3-beat packet to out1, sel only meaningful on the first beat
    out_ready = 2'b11;
    send2(8'hA1, 1'b0, 1'b1, 1);
    check("route_valid_b1", {30'd0, out_valid}, 32'h2);
    check("route_busy_open", {31'd0, busy}, 32'd1);
    send2(8'hA2, 1'b0, 1'b0, 1);
    check("route_valid_b2", {30'd0, out_valid}, 32'h2);
    send2(8'hA3, 1'b1, 1'b0, 1);
    check("route_valid_b3", {30'd0, out_valid}, 32'h2);
    check("route_busy_closed", {31'd0, busy}, 32'd0);

    // Select toggles mid-packet; everything stays on out1
    send2(8'hB1, 1'b0, 1'b1, 1);
    send2(8'hB2, 1'b0, 1'b0, 1);
    send2(8'hB3, 1'b1, 1'b1, 1);

    // Single-beat packet to out0 never opens a packet
    send2(8'hC1, 1'b1, 1'b0, 0);
    check("single_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure on out0
    out_ready = 2'b10;
    send2(8'h55, 1'b1, 1'b0, 0);
    @(posedge clk);
    #1;
    check("bp_valid0", {31'd0, out_valid[0]}, 32'd1);
    check("bp_data0", {24'd0, out_data[7:0]}, 32'h55);
    in_valid = 1'b1;
    in_data  = 8'h66;
    in_last  = 1'b1;
    in_sel   = 1'b0;
    #1;
    check("bp_in_ready_blocked", {31'd0, in_ready}, 32'd0);
    in_sel = 1'b1;
    #1;
    check("bp_other_out_free", {31'd0, in_ready}, 32'd1);
    in_sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp_in_ready_still0", {31'd0, in_ready}, 32'd0);
    check("bp_data_stable", {24'd0, out_data[7:0]}, 32'h55);
    check("bp_last_stable", {31'd0, out_last[0]}, 32'd1);
    out_ready = 2'b11;
    q0.push_back({1'b1, 8'h66});
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_reload_valid", {31'd0, out_valid[0]}, 32'd1);
    check("bp_reload_data", {24'd0, out_data[7:0]}, 32'h66);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a 4-beat packet to out1
    send2(8'hD1, 1'b0, 1'b1, 1);
    send2(8'hD2, 1'b0, 1'b0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {30'd0, out_valid}, 32'd0);
    send2(8'hE1, 1'b0, 1'b0, 0);
    check("newpkt_busy", {31'd0, busy}, 32'd1);
    send2(8'hE2, 1'b1, 1'b1, 0);
    check("newpkt_closed", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Out-of-range select on the 3-output instance
`ifdef STREAM_DEMUX_DROP_EN
    check("n3_drop_cnt_init", {16'd0, drop_cnt3}, 32'd0);
`endif
    v3 = 1'b1;
    d3 = 8'hF1;
    l3 = 1'b0;
    s3 = 2'd3;
    #1;
    check("n3_ready_b1", {31'd0, r3}, 32'd1);
`ifndef STREAM_DEMUX_DROP_EN
    q3.push_back({1'b0, 8'hF1});
`endif
    @(posedge clk);
    #1;
    check("n3_busy_open", {31'd0, busy3}, 32'd1);
`ifdef STREAM_DEMUX_DROP_EN
    check("n3_drop_cnt_1", {16'd0, drop_cnt3}, 32'd1);
`endif
    d3 = 8'hF2;
    l3 = 1'b1;
    s3 = 2'd0;
    #1;
    check("n3_ready_b2", {31'd0, r3}, 32'd1);
`ifndef STREAM_DEMUX_DROP_EN
    q3.push_back({1'b1, 8'hF2});
`endif
    @(posedge clk);
    #1;
    v3 = 1'b0;
    check("n3_busy_closed", {31'd0, busy3}, 32'd0);
`ifdef STREAM_DEMUX_DROP_EN
    check("n3_drop_cnt_hold", {16'd0, drop_cnt3}, 32'd1);
`endif
    repeat (4) @(posedge clk);
    #1;

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    check("q3_drained", q3.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
